// File: rtl/dmem_responder_if.sv
// dmem_responder_if: CPU data-memory bus plus the responder's status outputs.
//   memEn/memWrEn/memAddr/wrData : CPU -> responder request and store data
//   rdData                       : responder -> CPU load data (combinational)
//   wbValid/addrErr/errAddr      : write-buffer and address-error status
//   rdCount/wrCount              : saturating load/store counters
interface dmem_responder_if #(
  parameter int DW    = 128,
  parameter int CNT_W = 16
);
  logic             memEn;
  logic             memWrEn;
  logic [20:0]      memAddr;
  logic [DW-1:0]    wrData;
  logic [DW-1:0]    rdData;
  logic             wbValid;
  logic             addrErr;
  logic [20:0]      errAddr;
  logic [CNT_W-1:0] rdCount;
  logic [CNT_W-1:0] wrCount;

  modport master (
    output memEn, memWrEn, memAddr, wrData,
    input  rdData, wbValid, addrErr, errAddr, rdCount, wrCount
  );

  modport slave (
    input  memEn, memWrEn, memAddr, wrData,
    output rdData, wbValid, addrErr, errAddr, rdCount, wrCount
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: single-ported DEPTH x DW data memory behind the CPU dmem bus.
// Stores are posted into a one-entry write buffer (with read bypass); loads own
// the array port, and the buffer drains into the array on idle/error cycles.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : dmem_responder_if.slave (request, load data, status, counters)
//
// Write-buffer states:
//   state    | meaning
//   WB_EMPTY | no uncommitted store
//   WB_FULL  | buffer holds a store not yet written to the array
module dmem_responder #(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8,
  parameter int DW    = 128,
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);

  typedef enum logic {WB_EMPTY, WB_FULL} wb_state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  wb_state_e         state_q, state_d;
  logic [IDX_W-1:0]  wb_idx_q, wb_idx_d;
  logic [DW-1:0]     wb_data_q, wb_data_d;
  logic              addr_err_q, addr_err_d;
  logic [20:0]       err_addr_q, err_addr_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;

  logic [DW-1:0]     mem_q [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic              addr_ok;
  logic              acc_ld, acc_st, acc_err, drain_slot;
  logic              wb_full, wb_hit, commit;

  // Request decode. Accesses are masked while reset is held so rdData is
  // forced to zero immediately, not just at the next edge.
  always_comb begin
    idx        = bus.memAddr[IDX_W-1:0];
    addr_ok    = (bus.memAddr[20:IDX_W] == '0);
    acc_ld     = reset & bus.memEn & ~bus.memWrEn & addr_ok;
    acc_st     = reset & bus.memEn &  bus.memWrEn & addr_ok;
    acc_err    = reset & bus.memEn & ~addr_ok;
    drain_slot = ~bus.memEn | ~addr_ok;
  end

  // Buffer state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= WB_EMPTY;
    else        state_q <= state_d;
  end

  // Buffer next state: a load holds the buffer, a store (re)fills it
  always_comb begin
    state_d = state_q;
    case (state_q)
      WB_EMPTY: if (acc_st) state_d = WB_FULL;
      WB_FULL: begin
        if (acc_st)          state_d = WB_FULL;
        else if (drain_slot) state_d = WB_EMPTY;
      end
      default: state_d = WB_EMPTY;
    endcase
  end

  // Buffer outputs: bypass hit, array commit, load data
  always_comb begin
    wb_full = (state_q == WB_FULL);
    wb_hit  = wb_full && (wb_idx_q == idx);
    // A store to a different word evicts the old entry; a store to the same
    // word coalesces and never touches the array. Loads never commit, so the
    // array port sees at most one read or one write per cycle.
    commit  = wb_full && ((acc_st && !wb_hit) || drain_slot);
    bus.rdData  = '0;
    if (acc_ld) bus.rdData = wb_hit ? wb_data_q : mem_q[idx];
    bus.wbValid = wb_full;
  end

  always_comb begin
    wb_idx_d   = wb_idx_q;
    wb_data_d  = wb_data_q;
    addr_err_d = addr_err_q;
    err_addr_d = err_addr_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    if (acc_st) begin
      wb_idx_d  = idx;
      wb_data_d = bus.wrData;
      if (wr_cnt_q != CNT_MAX) wr_cnt_d = wr_cnt_q + 1'b1;
    end
    if (acc_ld && rd_cnt_q != CNT_MAX) rd_cnt_d = rd_cnt_q + 1'b1;
    // Only the first bad address is captured
    if (acc_err && !addr_err_q) begin
      addr_err_d = 1'b1;
      err_addr_d = bus.memAddr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_idx_q   <= '0;
      wb_data_q  <= '0;
      addr_err_q <= 1'b0;
      err_addr_q <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
    end else begin
      wb_idx_q   <= wb_idx_d;
      wb_data_q  <= wb_data_d;
      addr_err_q <= addr_err_d;
      err_addr_q <= err_addr_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  // Storage array is not reset; commit is already false while in reset
  always_ff @(posedge clk) begin
    if (commit) mem_q[wb_idx_q] <= wb_data_q;
  end

  assign bus.addrErr = addr_err_q;
  assign bus.errAddr = err_addr_q;
  assign bus.rdCount = rd_cnt_q;
  assign bus.wrCount = wr_cnt_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int CW   = 3;          // narrow counters so saturation is reached
  localparam int CMAX = (1 << CW) - 1;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  dmem_responder_if #(.DW(128), .CNT_W(CW)) bus();

  dmem_responder #(.DEPTH(256), .IDX_W(8), .DW(128), .CNT_W(CW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: committed memory plus at most one pending store that is visible
  // to loads and is lost on reset.
  logic [127:0] cmem [256];
  bit           cval [256];
  bit           pv    = 0;
  bit   [7:0]   pidx  = 0;
  logic [127:0] pdata = 0;
  bit           err   = 0;
  bit   [20:0]  eaddr = 0;
  int           rc    = 0;
  int           wc    = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_commit();
    cmem[pidx] = pdata;
    cval[pidx] = 1'b1;
    pv = 0;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pv = 0; err = 0; eaddr = 0; rc = 0; wc = 0;
    end else if (bus.memEn) begin
      if (bus.memAddr[20:8] != 0) begin
        if (!err) begin err = 1; eaddr = bus.memAddr; end
        if (pv) m_commit();
      end else if (bus.memWrEn) begin
        if (pv && pidx != bus.memAddr[7:0]) m_commit();
        pv = 1; pidx = bus.memAddr[7:0]; pdata = bus.wrData;
        if (wc < CMAX) wc++;
      end else begin
        if (rc < CMAX) rc++;
      end
    end else if (pv) begin
      m_commit();
    end
  end

  always @(negedge clk) begin
    logic [127:0] exp_rd;
    bit known;
    known  = 1;
    exp_rd = '0;
    if (reset && bus.memEn && !bus.memWrEn && bus.memAddr[20:8] == 0) begin
      if (pv && pidx == bus.memAddr[7:0])  exp_rd = pdata;
      else if (cval[bus.memAddr[7:0]])     exp_rd = cmem[bus.memAddr[7:0]];
      else                                 known  = 0;
    end
    if (known) chk("rdData", bus.rdData, exp_rd);
    chk("wbValid", 128'(bus.wbValid), 128'(pv));
    chk("addrErr", 128'(bus.addrErr), 128'(err));
    chk("errAddr", 128'(bus.errAddr), 128'(eaddr));
    chk("rdCount", 128'(bus.rdCount), 128'(rc));
    chk("wrCount", 128'(bus.wrCount), 128'(wc));
  end

  task automatic step(input bit en, input bit we, input logic [20:0] a, input logic [127:0] d);
    @(posedge clk);
    #1;
    bus.memEn   = en;
    bus.memWrEn = we;
    bus.memAddr = a;
    bus.wrData  = d;
  endtask

  localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] DA = 128'hAAAA_0000_1111_2222_3333_4444_5555_6666;
  localparam logic [127:0] DB = 128'hBBBB_7777_8888_9999_CCCC_DDDD_EEEE_FFFF;
  localparam logic [127:0] DX = 128'h5555_5555_5555_5555_5555_5555_5555_5555;

  initial begin
    for (int i = 0; i < 256; i++) begin cmem[i] = '0; cval[i] = 0; end
    bus.memEn = 0; bus.memWrEn = 0; bus.memAddr = '0; bus.wrData = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    chk("rst_wbValid", 128'(bus.wbValid), 128'd0);
    chk("rst_rdData",  bus.rdData, 128'd0);
    chk("rst_wrCount", 128'(bus.wrCount), 128'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    // 1: store then immediate load (bypass), drain, load from array
    step(0, 0, 21'd0, '0);
    step(1, 1, 21'd5, D1);
    step(1, 0, 21'd5, '0);
    #1 chk("t1_bypass", bus.rdData, D1);
    chk("t1_wbValid_on", 128'(bus.wbValid), 128'd1);
    step(0, 0, 21'd0, '0);
    step(1, 0, 21'd5, '0);
    #1 chk("t1_array", bus.rdData, D1);
    chk("t1_wbValid_off", 128'(bus.wbValid), 128'd0);

    // 2: coalesced stores
    step(1, 1, 21'd3, DA);
    step(1, 1, 21'd3, DB);
    step(0, 0, 21'd0, '0);
    step(1, 0, 21'd3, '0);
    #1 chk("t2_coalesce", bus.rdData, DB);
    chk("t2_wrCount", 128'(bus.wrCount), 128'd3);

    // 3: loads hold the buffer
    step(1, 1, 21'd7, DA);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 21'd9, '0);
      #1 chk("t3_hold", 128'(bus.wbValid), 128'd1);
    end
    step(0, 0, 21'd0, '0);
    step(1, 0, 21'd7, '0);
    #1 chk("t3_drained", bus.rdData, DA);
    chk("t3_rdCount", 128'(bus.rdCount), 128'd7);

    // 4: address errors, rdCount saturated at 7
    step(1, 0, 21'h000100, '0);
    #1 chk("t4_rd_zero", bus.rdData, 128'd0);
    chk("t4_rdCount_sat", 128'(bus.rdCount), 128'd7);
    step(1, 0, 21'h000200, '0);
    #1 chk("t4_addrErr", 128'(bus.addrErr), 128'd1);
    chk("t4_errAddr", 128'(bus.errAddr), 128'h100);
    step(0, 0, 21'd0, '0);
    #1 chk("t4_errAddr_kept", 128'(bus.errAddr), 128'h100);
    chk("t4_wrCount", 128'(bus.wrCount), 128'd4);

    // 5: back-to-back stores to different words
    step(1, 1, 21'd1, DA);
    step(1, 1, 21'd2, DB);
    step(1, 0, 21'd1, '0);
    #1 chk("t5_ld1", bus.rdData, DA);
    step(1, 0, 21'd2, '0);
    #1 chk("t5_ld2", bus.rdData, DB);

    // 6: reset discards a pending store
    step(1, 1, 21'd4, '0);
    step(0, 0, 21'd0, '0);
    step(1, 1, 21'd4, DX);
    step(1, 0, 21'd4, '0);
    chk("t6_wbValid_pre", 128'(bus.wbValid), 128'd1);
    chk("t6_wrCount_sat", 128'(bus.wrCount), 128'd7);
    #1 chk("t6_bypass", bus.rdData, DX);
    #1 reset = 1'b0;
    #1 chk("t6_rst_wbValid", 128'(bus.wbValid), 128'd0);
    chk("t6_rst_rdData", bus.rdData, 128'd0);
    chk("t6_rst_wrCount", 128'(bus.wrCount), 128'd0);
    bus.memEn = 0;
    @(posedge clk);
    #3 reset = 1'b1;
    step(1, 0, 21'd4, '0);
    #1 chk("t6_discarded", bus.rdData, 128'd0);
    chk("t6_wbValid_after", 128'(bus.wbValid), 128'd0);
    step(0, 0, 21'd0, '0);
    @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder at the far end of the CPU's dmem interface. The CPU drives memEn, memWrEn, memAddr and store data; this block returns load data and owns the storage array.
- Array is single-ported, DEPTH x 128 bits.
- Stores are posted through a one-entry write buffer, with read-after-write bypass.
- Reads get array-port priority; the buffer drains on idle cycles.
- Provides access counters and a sticky address-error flag for bench and debug visibility.

Parameters:
DEPTH, 256, number of 128-bit words; index width is log2(DEPTH)
IDX_W, 8, number of memAddr LSBs used as the word index
DW, 128, data width
CNT_W, 16, width of the access counters

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
memEn  input  1  access request; no access when 0
memWrEn  input  1  1 = store, 0 = load; qualified by memEn
memAddr  input  21  word address [0:20]; index = memAddr[21-IDX_W:20]; upper bits must be 0
wrData  input  DW  store data (the CPU's dataOut)
rdData  output  DW  load data (the CPU's dataIn); same-cycle, combinational
wbValid  output  1  write buffer holds an uncommitted store
addrErr  output  1  sticky out-of-range flag
errAddr  output  21  memAddr of the first out-of-range access
rdCount  output  CNT_W  accepted loads, saturating
wrCount  output  CNT_W  accepted stores, saturating

Behaviour:
- Reset (reset=0, asynchronous): wbValid=0, addrErr=0, errAddr=0, rdCount=0, wrCount=0, rdData=0.
  - Array contents are not reset; a read before any write returns X and is not checked.
- Range check:
  - In range: memAddr[0:20-IDX_W] == 0.
  - Out of range with memEn=1: access ignored, no counter change, rdData=0.
  - The first such access sets addrErr=1 and captures errAddr at the edge; later errors do not update errAddr.
  - addrErr is cleared only by reset.
- Load (memEn=1, memWrEn=0, in range):
  - Zero latency: rdData is driven in the same cycle.
  - If wbValid and the buffer address equals the index, rdData = buffer data; otherwise rdData = array[index].
  - Consumes the array port for the cycle.
  - rdCount increments at the edge; saturates at 2^CNT_W-1.
- rdData = 0 whenever there is no in-range load (idle, store or error cycle).
- Store (memEn=1, memWrEn=1, in range), at the edge:
  - If wbValid and the buffer address differs from the index: commit the buffer to the array, then load the new store into the buffer.
  - If wbValid and the buffer address equals the index: overwrite the buffer data (coalesce); no array write.
  - If the buffer is empty: load it.
  - wbValid=1 afterwards.
  - wrCount increments (saturating); a coalesced store still counts.
- Drain:
  - On any edge where wbValid=1 and the cycle is idle or an error cycle, commit the buffer to the array and set wbValid=0.
  - On an in-range load cycle the buffer holds.
- Write-port rule: at most one array write per edge; an array read and an array write never occur in the same cycle.
- memWrEn with memEn=0 is ignored.
- Reset mid-operation: a pending buffered store is discarded (wbValid=0); the array keeps any already-committed data.
- Once loaded, a buffered store is always observable through the bypass until committed.

Test Plan:
1. Reset, idle 1 cycle, then store 0x0123..EF at addr 5 followed immediately by a load at addr 5 -> rdData=stored value (bypass) with wbValid=1. Next idle cycle -> wbValid=0; a load at addr 5 still returns the value from the array.
2. Store A at 3, store B at 3, then idle -> wrCount=2 and a single commit; a load at 3 returns B.
3. Store A at 7, then 4 consecutive loads at addr 9 -> wbValid stays 1 throughout; an idle cycle drains it; a load at 7 returns A; rdCount=4.
4. Load at memAddr=0x000100 (bit above index set) -> rdData=0, addrErr=1, errAddr=0x000100, counters unchanged. A second error at 0x000200 leaves errAddr=0x000100.
5. Store A at 1, store B at 2 back-to-back -> A is committed when B is buffered; loads at 1 and 2 return A and B.
6. Store at 4, assert reset low mid-cycle before any idle cycle -> outputs zero immediately. After release, wbValid=0 and the address-4 contents are not updated (bench pre-writes 0 there, then expects 0).
